// File: rtl/maxpool_flatten.sv
// 2x2 stride-2 max-pool over a BRAM feature map, writing a channel-major flattened vector.
// Optional fused ReLU on the written value when MAXPOOL_RELU_EN is defined.
module maxpool_flatten #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_H       = 28,
    parameter int IN_W       = 28,
    localparam int OUT_H     = IN_H / 2,
    localparam int OUT_W     = IN_W / 2,
    localparam int IN_DEPTH  = CHANNELS * IN_H * IN_W,
    localparam int OUT_DIM   = CHANNELS * OUT_H * OUT_W,
    localparam int IN_AW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1,
    localparam int OUT_AW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [IN_AW-1:0]             rd_addr,
    output logic                         rd_en,
    input  logic signed [DATA_WIDTH-1:0] rd_q,
    output logic [OUT_AW-1:0]            wr_addr,
    output logic                         wr_en,
    output logic signed [DATA_WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         done
);

    localparam int C_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int PX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [C_W-1:0]  C_LAST  = C_W'(CHANNELS - 1);
    localparam logic [PY_W-1:0] PY_LAST = PY_W'(OUT_H - 1);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(OUT_W - 1);

    if ((IN_H % 2) != 0 || (IN_W % 2) != 0) begin : g_odd_dims
        $fatal(1, "maxpool_flatten: IN_H and IN_W must both be even");
    end

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [1:0]                   k, k_n;
    logic [C_W-1:0]               c, c_n;
    logic [PY_W-1:0]              py, py_n;
    logic [PX_W-1:0]              px, px_n;
    logic signed [DATA_WIDTH-1:0] mx, mx_n;
    logic signed [DATA_WIDTH-1:0] pooled;
    logic                         last_window;

    logic                         rd_en_n, wr_en_n, busy_n, done_n;
    logic [IN_AW-1:0]             rd_addr_n;
    logic [OUT_AW-1:0]            wr_addr_n;
    logic signed [DATA_WIDTH-1:0] wr_data_n;

    // Tap k of window (yi, xi): bit 1 selects the lower row, bit 0 the right column.
    function automatic logic [IN_AW-1:0] tap_addr(
        input logic [C_W-1:0]  ci,
        input logic [PY_W-1:0] yi,
        input logic [PX_W-1:0] xi,
        input logic [1:0]      ki
    );
        int unsigned a;
        a = 32'(ci) * 32'(IN_H * IN_W)
          + (32'(yi) * 32'd2 + 32'(ki[1])) * 32'(IN_W)
          + 32'(xi) * 32'd2 + 32'(ki[0]);
        return a[IN_AW-1:0];
    endfunction

    function automatic logic [OUT_AW-1:0] out_index(
        input logic [C_W-1:0]  ci,
        input logic [PY_W-1:0] yi,
        input logic [PX_W-1:0] xi
    );
        int unsigned a;
        a = 32'(ci) * 32'(OUT_H * OUT_W) + 32'(yi) * 32'(OUT_W) + 32'(xi);
        return a[OUT_AW-1:0];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] cur,
        input logic signed [DATA_WIDTH-1:0] cand
    );
        return (cand > cur) ? cand : cur;
    endfunction

    assign last_window = (c == C_LAST) && (py == PY_LAST) && (px == PX_LAST);
    assign pooled      = smax(mx, rd_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            c       <= '0;
            py      <= '0;
            px      <= '0;
            mx      <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            c       <= c_n;
            py      <= py_n;
            px      <= px_n;
            mx      <= mx_n;
            rd_en   <= rd_en_n;
            rd_addr <= rd_addr_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    // rd_q in READ step k (k>=1) carries tap k-1; DRAIN carries tap 3.
    always_comb begin
        state_n   = state;
        k_n       = k;
        c_n       = c;
        py_n      = py;
        px_n      = px;
        mx_n      = mx;
        rd_en_n   = 1'b0;
        rd_addr_n = rd_addr;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        busy_n    = busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = READ;
                    k_n       = '0;
                    c_n       = '0;
                    py_n      = '0;
                    px_n      = '0;
                    rd_en_n   = 1'b1;
                    rd_addr_n = '0;
                    busy_n    = 1'b1;
                end
            end

            READ: begin
                if (k == 2'd1) begin
                    mx_n = rd_q;
                end else if (k != 2'd0) begin
                    mx_n = pooled;
                end
                if (k == 2'd3) begin
                    state_n = DRAIN;
                end else begin
                    k_n       = k + 2'd1;
                    rd_en_n   = 1'b1;
                    rd_addr_n = tap_addr(c, py, px, k + 2'd1);
                end
            end

            DRAIN: begin
                mx_n      = pooled;
                wr_en_n   = 1'b1;
                wr_addr_n = out_index(c, py, px);
`ifdef MAXPOOL_RELU_EN
                wr_data_n = pooled[DATA_WIDTH-1] ? '0 : pooled;
`else
                wr_data_n = pooled;
`endif
                state_n   = WRITE;
            end

            WRITE: begin
                if (last_window) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                end else begin
                    if (px == PX_LAST) begin
                        px_n = '0;
                        if (py == PY_LAST) begin
                            py_n = '0;
                            c_n  = c + C_W'(1);
                        end else begin
                            py_n = py + PY_W'(1);
                        end
                    end else begin
                        px_n = px + PX_W'(1);
                    end
                    state_n   = READ;
                    k_n       = '0;
                    rd_en_n   = 1'b1;
                    rd_addr_n = tap_addr(c_n, py_n, px_n, 2'd0);
                end
            end

            FINISH: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The write port and read port must never be active together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(rd_en && wr_en))
                else $error("maxpool_flatten: rd_en and wr_en both high");
            assert (!done || busy)
                else $error("maxpool_flatten: done without busy");
        end
    end

endmodule

// File: tb/tb_maxpool_flatten.sv
// Self-checking bench for maxpool_flatten: 2 channels of 4x4, a 1-cycle BRAM model and a
// behavioural max-pool reference; honours MAXPOOL_RELU_EN when it is defined.
module tb_maxpool_flatten;

    localparam int DW      = 16;
    localparam int CH      = 2;
    localparam int H       = 4;
    localparam int W       = 4;
    localparam int OH      = H / 2;
    localparam int OW      = W / 2;
    localparam int NIN     = CH * H * W;
    localparam int NOUT    = CH * OH * OW;
    localparam int IAW     = $clog2(NIN);
    localparam int OAW     = $clog2(NOUT);
    localparam int DONE_AT = 6 * NOUT + 1;
    localparam int LIMIT   = 6 * NOUT + 30;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [IAW-1:0]       rd_addr;
    logic                 rd_en;
    logic signed [DW-1:0] rd_q;
    logic [OAW-1:0]       wr_addr;
    logic                 wr_en;
    logic signed [DW-1:0] wr_data;
    logic                 busy;
    logic                 done;

    maxpool_flatten #(
        .DATA_WIDTH(DW),
        .CHANNELS  (CH),
        .IN_H      (H),
        .IN_W      (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_en  (rd_en),
        .rd_q   (rd_q),
        .wr_addr(wr_addr),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [0:NIN-1];

    always @(posedge clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_rec_t;

    typedef struct {
        int addr;
        int data;
    } ramp_vec_t;

    typedef struct {
        int taps[4];
        int exp_plain;
        int exp_relu;
    } win_vec_t;

    wr_rec_t   wq[$];
    int        rdq_addr[$];
    int        rdq_cyc[$];
    int        done_cyc[$];
    int        overlap;
    int        busy_cnt;
    int        post_rst_bad;
    int        base;
    int        exp_out [0:NOUT-1];
    ramp_vec_t rtab [0:NOUT-1];
    win_vec_t  wtab [0:5];

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic sampleOutputs(input int cyc, input int rst_cyc);
        if (wr_en) wq.push_back('{int'(wr_addr), int'(wr_data), cyc});
        if (rd_en) begin
            rdq_addr.push_back(int'(rd_addr));
            rdq_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (rd_en && wr_en) overlap++;
        if (busy) busy_cnt++;
        if (rst_cyc >= 0 && cyc > rst_cyc) begin
            if (rd_en || wr_en || done || busy || rd_addr != '0 || wr_addr != '0 || wr_data != '0)
                post_rst_bad++;
        end
    endtask

    // Pulses start in cycle 0, optionally re-pulses at p1/p2 and resets in rst_cyc.
    task automatic applyStimulus(input int p1, input int p2, input int rst_cyc);
        int cyc;
        bit fin;
        wq.delete();
        rdq_addr.delete();
        rdq_cyc.delete();
        done_cyc.delete();
        overlap      = 0;
        busy_cnt     = 0;
        post_rst_bad = 0;
        @(negedge clk);
        base  = edge_cnt;
        start = 1'b1;
        sampleOutputs(0, rst_cyc);
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc   = edge_cnt - base;
            start = (cyc == p1) || (cyc == p2);
            if (rst_cyc >= 0) reset = (cyc == rst_cyc);
            sampleOutputs(cyc, rst_cyc);
            if (rst_cyc >= 0) fin = (cyc >= rst_cyc + 20);
            else              fin = done || (cyc >= LIMIT);
        end
    endtask

    function automatic int idx(input int c, input int y, input int x);
        return c * H * W + y * W + x;
    endfunction

    task automatic buildModel();
        int m;
        for (int c = 0; c < CH; c++)
            for (int py = 0; py < OH; py++)
                for (int px = 0; px < OW; px++) begin
                    m = int'(mem[idx(c, 2 * py, 2 * px)]);
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++)
                            if (int'(mem[idx(c, 2 * py + dy, 2 * px + dx)]) > m)
                                m = int'(mem[idx(c, 2 * py + dy, 2 * px + dx)]);
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    exp_out[c * OH * OW + py * OW + px] = m;
                end
    endtask

    task automatic checkPass(input string tag);
        checkOutput({tag, " write count"}, wq.size(), NOUT);
        for (int i = 0; i < wq.size() && i < NOUT; i++) begin
            checkOutput($sformatf("%s w%0d addr", tag, i), wq[i].addr, i);
            checkOutput($sformatf("%s w%0d data", tag, i), wq[i].data, exp_out[i]);
            checkOutput($sformatf("%s w%0d cycle", tag, i), wq[i].cyc, 6 * i + 6);
        end
        checkOutput({tag, " done count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) checkOutput({tag, " done cycle"}, done_cyc[0], DONE_AT);
        checkOutput({tag, " rd/wr overlap"}, overlap, 0);
        checkOutput({tag, " busy cycles"}, busy_cnt, DONE_AT);
        checkOutput({tag, " read count"}, rdq_addr.size(), 4 * NOUT);
    endtask

    task automatic fillRamp();
        for (int i = 0; i < NIN; i++) mem[i] = DW'(i);
    endtask

    task automatic fillRandom(input bit narrow);
        for (int i = 0; i < NIN; i++) begin
            if (narrow) mem[i] = DW'(int'($urandom_range(0, 20)) - 10);
            else        mem[i] = DW'($urandom);
        end
    endtask

    task automatic setWin(input int i, input int a, input int b, input int c, input int d,
                          input int ep, input int er);
        wtab[i].taps[0] = a;
        wtab[i].taps[1] = b;
        wtab[i].taps[2] = c;
        wtab[i].taps[3] = d;
        wtab[i].exp_plain = ep;
        wtab[i].exp_relu  = er;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, a, ex;

        rtab[0] = '{0, 5};  rtab[1] = '{1, 7};  rtab[2] = '{2, 13}; rtab[3] = '{3, 15};
        rtab[4] = '{4, 21}; rtab[5] = '{5, 23}; rtab[6] = '{6, 29}; rtab[7] = '{7, 31};
        setWin(0, -5, -3, -9, -7, -3, 0);
        setWin(1, -32768, -32768, -32768, -32767, -32767, 0);
        setWin(2, 32767, -32768, 0, 1, 32767, 32767);
        setWin(3, -1, 0, -1, -1, 0, 0);
        setWin(4, 7, 7, 7, 7, 7, 7);
        setWin(5, -100, -200, -50, -300, -50, 0);

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset rd_en", int'(rd_en), 0);
        checkOutput("reset wr_en", int'(wr_en), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset rd_addr", int'(rd_addr), 0);
        checkOutput("reset wr_addr", int'(wr_addr), 0);
        checkOutput("reset wr_data", int'(wr_data), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] ramp content");
        fillRamp();
        buildModel();
        applyStimulus(-1, -1, -1);
        checkPass("ramp");
        for (int i = 0; i < NOUT; i++) begin
            if (i < wq.size()) begin
                checkOutput($sformatf("ramp table w%0d addr", i), wq[i].addr, rtab[i].addr);
                checkOutput($sformatf("ramp table w%0d data", i), wq[i].data, rtab[i].data);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < rdq_addr.size()) begin
                checkOutput($sformatf("window0 tap%0d rd_addr", i), rdq_addr[i], (i / 2) * W + (i % 2));
                checkOutput($sformatf("window0 tap%0d rd cycle", i), rdq_cyc[i], i + 1);
            end
        end
        if (rdq_cyc.size() > 4) checkOutput("window1 first rd cycle", rdq_cyc[4], 7);

        $display("[TB] max-position sweep");
        for (int i = 0; i < NIN; i++) mem[i] = -16'sd100;
        for (int w = 0; w < NOUT; w++) begin
            t = w % 4;
            a = idx(w / (OH * OW), 2 * ((w / OW) % OH) + t / 2, 2 * (w % OW) + t % 2);
            mem[a] = DW'(40 + w);
        end
        buildModel();
        applyStimulus(-1, -1, -1);
        checkPass("sweep");
        for (int w = 0; w < NOUT && w < wq.size(); w++)
            checkOutput($sformatf("sweep w%0d value", w), wq[w].data, 40 + w);

        $display("[TB] window table");
        for (int v = 0; v < 6; v++) begin
            fillRandom(1'b0);
            for (int i = 0; i < 4; i++) mem[(i / 2) * W + (i % 2)] = DW'(wtab[v].taps[i]);
            buildModel();
            applyStimulus(-1, -1, -1);
`ifdef MAXPOOL_RELU_EN
            ex = wtab[v].exp_relu;
`else
            ex = wtab[v].exp_plain;
`endif
            if (wq.size() > 0) checkOutput($sformatf("table v%0d addr0 data", v), wq[0].data, ex);
            else               checkOutput($sformatf("table v%0d write seen", v), 0, 1);
            checkPass($sformatf("table v%0d", v));
        end

        $display("[TB] random passes");
        for (int r = 0; r < 4; r++) begin
            fillRandom(r[0]);
            buildModel();
            applyStimulus(-1, -1, -1);
            checkPass($sformatf("random%0d", r));
        end

        $display("[TB] start while busy");
        fillRamp();
        buildModel();
        applyStimulus(10, DONE_AT, -1);
        checkPass("busy pulses");
        applyStimulus(-1, -1, -1);
        checkPass("start at cycle 50");

        $display("[TB] reset mid-operation");
        applyStimulus(-1, -1, 20);
        checkOutput("reset-mid writes before reset", wq.size(), 3);
        checkOutput("reset-mid activity after reset", post_rst_bad, 0);
        checkOutput("reset-mid done count", done_cyc.size(), 0);
        applyStimulus(-1, -1, -1);
        checkPass("after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxpool_flatten.md
# maxpool_flatten

2×2 stride-2 max-pool that reads a conv feature map from a synchronous BRAM and writes the pooled, flattened vector into the BRAM that feeds the fully-connected layer. The block sits directly upstream of the dense stage: its write port drives the dense input buffer, and its `done` pulse is the dense layer's `start`. Output order is channel-major, which matches the dense layer's `IN_DIM` indexing.

## Interface
- `DATA_WIDTH`, default 16: signed fixed-point sample width, same as the conv and dense stages.
- `CHANNELS`, default 8: feature-map channels.
- `IN_H`, default 28: input rows. Must be even.
- `IN_W`, default 28: input columns. Must be even.
- Derived: `OUT_H = IN_H/2`, `OUT_W = IN_W/2`, `IN_DEPTH = CHANNELS*IN_H*IN_W`, `OUT_DIM = CHANNELS*OUT_H*OUT_W` (default 1568).
- Derived: `IN_AW` and `OUT_AW` are `$clog2` of their depths, minimum 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `rd_addr`  out  IN_AW  feature-map read address, `c*IN_H*IN_W + y*IN_W + x`.
- `rd_en`  out  1  read enable.
- `rd_q`  in  DATA_WIDTH signed  read data, valid the cycle after `rd_en`.
- `wr_addr`  out  OUT_AW  output index, `c*OUT_H*OUT_W + py*OUT_W + px`.
- `wr_en`  out  1  write strobe.
- `wr_data`  out  DATA_WIDTH signed  pooled value.
- `busy`  out  1  high from start acceptance through the FINISH cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, FINISH.
- IDLE: on `start`, clear the counters `c`, `py`, `px`, clear `k`, and go to READ.
- READ: the phase counter `k` steps 0..3. `rd_en` is high and `rd_addr` selects the window taps in this order: (2py,2px), (2py,2px+1), (2py+1,2px), (2py+1,2px+1).
- READ exit: after `k=3`, go to DRAIN.
- Running max `mx`:
  - In the cycle after each read, the returned `rd_q` updates `mx`.
  - The first tap loads `mx` directly. Later taps apply `mx = (rd_q > mx) ? rd_q : mx`, using a signed compare.
  - DRAIN consumes the fourth tap.
- WRITE: `wr_en` is high for one cycle with `wr_addr` equal to the flat output index and `wr_data` equal to `mx`.
- Counter advance after WRITE: `px` first, then `py`, then `c`. After the last window (c=CHANNELS-1, py=OUT_H-1, px=OUT_W-1) go to FINISH; otherwise return to READ with `k=0`.
- FINISH: `done` is high for one cycle, then go to IDLE.
- `start` outside IDLE is ignored, including during the FINISH cycle.
- No arithmetic beyond comparison, so no widening or saturation.
- `IN_H` or `IN_W` odd: elaboration-time `$fatal`.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Window n (n = 0..OUT_DIM-1) occupies:
  - READ: cycles 6n+1 to 6n+4.
  - DRAIN: cycle 6n+5.
  - WRITE: cycle 6n+6.
- `done` is high in cycle 6*OUT_DIM+1. Next start is accepted from cycle 6*OUT_DIM+2.
- `rd_en` and `wr_en` are never high in the same cycle.
- All outputs are registered.
- Reset values: `rd_en=0`, `wr_en=0`, `done=0`, `busy=0`, `rd_addr=0`, `wr_addr=0`, `wr_data=0`, state IDLE.
- Reset mid-operation: outputs return to the values above on the next edge and no further reads or writes occur. A fresh `start` restarts from window 0.

## Configuration
- `MAXPOOL_RELU_EN` defined: fused ReLU. In WRITE, `wr_data = (mx < 0) ? 0 : mx`.
- Not defined: `wr_data = mx`, and negative maxima pass unchanged.
- Timing is identical in both builds.

## Test plan
All scenarios use CHANNELS=2, IN_H=IN_W=4 (OUT_DIM=8) with a 1-cycle-latency BRAM model.

- **Ramp content.** Feature map `in[i]=i`.
  - Writes must be (addr:data) 0:5, 1:7, 2:13, 3:15, 4:21, 5:23, 6:29, 7:31, in that order, and exactly 8 writes total.
  - `done` must be high in cycle 49.
- **Max-position sweep.** All samples -100. In window w, tap (w mod 4) holds 40+w.
  - Each output must equal 40+w, proving every tap position and the signed compare.
- **Negative window.** Channel 0 window 0 holds {-5,-3,-9,-7}.
  - Without `MAXPOOL_RELU_EN`: `wr_data=-3` at addr 0.
  - With `MAXPOOL_RELU_EN`: `wr_data=0` at addr 0.
- **Read sequence check.** Check the `rd_addr` sequence for window 0: 0, 1, 4, 5.
  - `rd_en` high in exactly cycles 1-4.
  - `wr_en` high only in cycle 6.
- **Start while busy.** Pulse `start` again at cycles 10 and 49.
  - Both pulses are ignored: exactly 8 writes, `done` only in cycle 49.
  - A pulse at cycle 50 must start a second pass.
- **Reset mid-operation.** Assert `reset` in cycle 20.
  - All outputs must be 0 from the next edge onward, with no writes until a new start.
  - A restarted pass must reproduce the ramp results.
